// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } feeder_state_t;

    typedef logic [7:0] uart_byte_t;

    // Parity selection codes understood by the UART top
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    // Baud-rate selection codes understood by the UART top
    localparam logic [1:0] BAUD_9600   = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    // Width needed to hold a FIFO occupancy of 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered occupancy count
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Flags come straight from the registered count so they track it exactly
    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host bytes and paces them into the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          busy,
    output logic          tx_send,
    output logic [7:0]    tx_data,
    input  logic          tx_active_flag,
    input  logic          tx_done_flag
);

    feeder_state_t r_state;
    feeder_state_t w_next_state;
    logic          r_tx_send;
    uart_byte_t    r_tx_data;
    logic          r_overflow;
    logic          w_pop;
    uart_byte_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .wdata (wr_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE);
    assign tx_send  = r_tx_send;
    assign tx_data  = r_tx_data;

    // Next-state logic; done in REQ wins over active so a fast transmitter cannot hang us
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (tx_done_flag) begin
                    w_next_state = GAP;
                end else if (tx_active_flag) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done_flag) begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // send is registered and high exactly while the FSM sits in REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_send <= 1'b0;
        end else begin
            r_tx_send <= (w_next_state == REQ);
        end
    end

    // Byte latched on pop and held until the next pop, covering REQ through GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= 8'h00;
        end else if (w_pop) begin
            r_tx_data <= w_head;
        end
    end

    // Sticky drop flag; a new drop outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder with a transmitter responder
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          man_done = 1'b0;
    logic          resp_active = 1'b0;
    logic          resp_done = 1'b0;
    logic          tx_active_flag;
    logic          tx_done_flag;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;
    logic          tx_send;
    logic [7:0]    tx_data;

    assign tx_active_flag = resp_active;
    assign tx_done_flag   = resp_done | man_done;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .clr_ovf        (clr_ovf),
        .full           (full),
        .empty          (empty),
        .level          (level),
        .overflow       (overflow),
        .busy           (busy),
        .tx_send        (tx_send),
        .tx_data        (tx_data),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO contents as a queue, frame timing as "busy until one cycle after done"
    logic [7:0] exp_q[$];
    logic [7:0] sb_q[$];
    int         cyc = 0;
    bit         m_frame = 0;
    bit         m_send = 0;
    bit         m_ovf = 0;
    bit         m_done_seen = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) begin : model
        int L;
        bit may_pop;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_frame = 0; m_send = 0; m_done_seen = 0; m_data = 8'h00;
        end else begin
            L = exp_q.size();
            may_pop = !m_frame && (L > 0);
            if (wr_en && L == DEPTH) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (m_frame) begin
                if (m_done_seen) m_frame = 0;
                else if (tx_done_flag) begin m_done_seen = 1; m_send = 0; end
                else if (tx_active_flag) m_send = 0;
            end
            if (may_pop) begin
                m_data = exp_q.pop_front();
                m_frame = 1; m_send = 1; m_done_seen = 0;
            end
            if (wr_en && L < DEPTH) begin
                exp_q.push_back(wr_data);
                sb_q.push_back(wr_data);
            end
        end
    end

    // Transmitter responder: mode 0 active then done, mode 1 done only, mode 2 silent
    int resp_mode = 0;
    int resp_phase = 0;
    int resp_cnt = 0;

    always @(negedge clk) begin : responder
        if (rst || resp_mode == 2) begin
            resp_phase = 0; resp_active = 0; resp_done = 0;
        end else begin
            case (resp_phase)
                0: begin
                    resp_active = 0; resp_done = 0;
                    if (tx_send) begin resp_cnt = $urandom_range(0, 3); resp_phase = 1; end
                end
                1: begin
                    if (resp_cnt > 0) resp_cnt--;
                    else if (resp_mode == 0) begin
                        resp_active = 1; resp_cnt = $urandom_range(0, 4); resp_phase = 2;
                    end else begin
                        resp_done = 1; resp_phase = 3;
                    end
                end
                2: begin
                    resp_active = 0;
                    if (resp_cnt > 0) resp_cnt--;
                    else begin resp_done = 1; resp_phase = 3; end
                end
                default: begin resp_done = 0; resp_phase = 0; end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle output comparison plus frame-start scoreboard pops
    int sb_rd = 0;
    bit prev_send = 0;
    int to_req = 0;
    int to_seen = 0;
    bit end_req = 0;
    bit end_done = 0;

    always @(negedge clk) begin : mon
        if (cyc > 0) begin
            check("level", level, exp_q.size());
            check("full", full, exp_q.size() == DEPTH);
            check("empty", empty, exp_q.size() == 0);
            check("overflow", overflow, m_ovf);
            check("busy", busy, m_frame);
            check("tx_send", tx_send, m_send);
            check("tx_data", tx_data, m_data);
            if (rst) begin
                sb_rd = sb_q.size();
            end else if (tx_send && !prev_send) begin
                if (sb_rd >= sb_q.size()) check("frame_unexpected", sb_rd, sb_q.size() - 1);
                else begin
                    check("frame_byte", tx_data, sb_q[sb_rd]);
                    sb_rd++;
                end
            end
            prev_send = tx_send;
        end
        if (to_req != to_seen) begin
            check("wait_timeout", to_seen, to_req);
            to_seen = to_req;
        end
        if (end_req && !end_done) begin
            check("frames_unsent", sb_q.size() - sb_rd, 0);
            end_done = 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1; wr_data = b; tick(); wr_en = 0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin tick(); t++; end
        if (t >= budget) to_req++;
    endtask

    initial begin : stim
        int t;
        rst = 1; tick(3); rst = 0; tick(2);

        // single byte
        resp_mode = 0;
        push(8'hA5);
        drain(200); tick(2);

        // burst 01..05 back to back
        for (int b = 1; b <= 5; b++) begin wr_en = 1; wr_data = 8'(b); tick(); end
        wr_en = 0;
        drain(500); tick(2);

        // reset held two cycles while in REQ
        resp_mode = 2;
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        t = 0;
        while (!tx_send && t < 50) begin tick(); t++; end
        if (t >= 50) to_req++;
        rst = 1; tick(2); rst = 0; tick(2);

        // fill to full with the transmitter stalled, then overflow
        for (int i = 0; i < 18; i++) begin wr_en = 1; wr_data = 8'($urandom); tick(); end
        wr_en = 0; tick();
        clr_ovf = 1; tick(); clr_ovf = 0; tick();
        wr_en = 1; clr_ovf = 1; wr_data = 8'h77; tick();
        wr_en = 0; clr_ovf = 0; tick();
        resp_mode = 0;
        drain(2000); tick(2);

        // push on the IDLE pop cycle with three bytes queued
        resp_mode = 2;
        push(8'h10); tick(2);
        push(8'h11); push(8'h12); push(8'h13);
        man_done = 1; tick(); man_done = 0;
        tick();
        push(8'h14);
        tick(2);
        resp_mode = 0;
        drain(500); tick(2);

        // fast transmitter: done without active
        resp_mode = 1;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        drain(500); tick(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) resp_mode = $urandom_range(0, 1);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1; tick(2); rst = 0;
            end else begin
                tick();
            end
        end
        wr_en = 0; clr_ovf = 0; resp_mode = 0;
        drain(3000); tick(3);

        end_req = 1;
        t = 0;
        while (!end_done && t < 10) begin tick(); t++; end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
